// File: rtl/comma_inserter.sv
// Transmit lane framer: alignment comma bursts, idle comma fill and a periodic forced comma.
// It packs payload words behind a one-cycle registered output stage.
module comma_inserter #(
  parameter int         BYTES     = 4,
  parameter logic [7:0] COMMA     = 8'hBC,
  parameter logic [7:0] FILL      = 8'h50,
  parameter int         ALIGN_LEN = 16,
  parameter int         PERIOD    = 1024
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [BYTES*8-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               realign_i,
  output logic [BYTES*8-1:0] data_o,
  output logic [BYTES-1:0]   comma_o,
  output logic               aligned_o
);

  localparam int DW = BYTES * 8;
  localparam int PW = $clog2(PERIOD);
  localparam int BW = (ALIGN_LEN > 1) ? $clog2(ALIGN_LEN) : 1;
  localparam logic [PW-1:0]    PER_LAST    = PW'(PERIOD - 1);
  localparam logic [BW-1:0]    BURST_LAST  = BW'(ALIGN_LEN - 1);
  localparam logic [BYTES-1:0] COMMA_FLAG  = BYTES'(1);

  typedef enum logic {ST_ALIGN = 1'b0, ST_RUN = 1'b1} state_t;

  logic [DW-1:0] comma_word;

  // Byte 0 carries the K character; all other lanes carry the fill character.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_comma
    assign comma_word[8*gi +: 8] = (gi == 0) ? COMMA : FILL;
  end

  state_t         state_q, state_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [PW-1:0]  per_q, per_d;
  logic [DW-1:0]  data_q, data_d;
  logic [BYTES-1:0] comma_q, comma_d;
  logic           ready_q, ready_d;
  logic           aligned_q, aligned_d;

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    per_d   = per_q;
    data_d  = comma_word;
    comma_d = COMMA_FLAG;

    if (state_q == ST_ALIGN) begin
      per_d = '0;
      if (realign_i) begin
        burst_d = '0;
      end else if (burst_q == BURST_LAST) begin
        state_d = ST_RUN;
        burst_d = '0;
      end else begin
        burst_d = burst_q + 1'b1;
      end
    end else begin
      // ready_q is low exactly in the forced-comma slot, so this also covers that case.
      if (ready_q && valid_i) begin
        data_d  = data_i;
        comma_d = '0;
        per_d   = per_q + 1'b1;
      end else begin
        per_d = '0;
      end
      if (realign_i) begin
        state_d = ST_ALIGN;
        burst_d = '0;
        per_d   = '0;
      end
    end

    ready_d   = (state_d == ST_RUN) && (per_d != PER_LAST);
    aligned_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_ALIGN;
      burst_q   <= '0;
      per_q     <= '0;
      data_q    <= '0;
      comma_q   <= '0;
      ready_q   <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      per_q     <= per_d;
      data_q    <= data_d;
      comma_q   <= comma_d;
      ready_q   <= ready_d;
      aligned_q <= aligned_d;
    end
  end

  assign data_o    = data_q;
  assign comma_o   = comma_q;
  assign ready_o   = ready_q;
  assign aligned_o = aligned_q;

endmodule

// File: tb/tb_comma_inserter.sv
// Bench for comma_inserter: two instances (PERIOD=1024 and PERIOD=4) share stimulus and are checked
// every cycle against a word-count model, plus a directed vector table and hand sequences.
module tb_comma_inserter;

  localparam int          ALIGN_LEN = 16;
  localparam logic [31:0] COMMA_W   = 32'h505050BC;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        valid = 1'b0;
  logic        realign = 1'b0;
  logic [31:0] din = '0;

  logic [31:0] dout0, dout1;
  logic [3:0]  cm0, cm1;
  logic        rdy0, rdy1, al0, al1;

  always #5 clk = ~clk;

  comma_inserter u_dut0 (
    .clk_i(clk), .rstn_i(rstn), .data_i(din), .valid_i(valid), .ready_o(rdy0),
    .realign_i(realign), .data_o(dout0), .comma_o(cm0), .aligned_o(al0)
  );

  comma_inserter #(.PERIOD(4)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .data_i(din), .valid_i(valid), .ready_o(rdy1),
    .realign_i(realign), .data_o(dout1), .comma_o(cm1), .aligned_o(al1)
  );

  // Model: commas still owed in the current burst, and data words since the last comma.
  int          m_left [2];
  int          m_run  [2];
  logic [31:0] e_data [2];
  logic [3:0]  e_comma[2];
  logic        e_rdy  [2];
  logic        e_al   [2];
  bit          acc    [2];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic int per_of(int k);
    return (k == 0) ? 1024 : 4;
  endfunction

  task automatic chk(string tag, string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h (t=%0t)", tag, name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    chk(tag, "data0",    dout0, e_data[0]);
    chk(tag, "comma0",   32'(cm0), 32'(e_comma[0]));
    chk(tag, "ready0",   32'(rdy0), 32'(e_rdy[0]));
    chk(tag, "aligned0", 32'(al0), 32'(e_al[0]));
    chk(tag, "data1",    dout1, e_data[1]);
    chk(tag, "comma1",   32'(cm1), 32'(e_comma[1]));
    chk(tag, "ready1",   32'(rdy1), 32'(e_rdy[1]));
    chk(tag, "aligned1", 32'(al1), 32'(e_al[1]));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k]  = ALIGN_LEN;
      m_run[k]   = 0;
      e_data[k]  = '0;
      e_comma[k] = '0;
      e_rdy[k]   = 1'b0;
      e_al[k]    = 1'b0;
      acc[k]     = 1'b0;
    end
  endtask

  task automatic predict();
    for (int k = 0; k < 2; k++) begin
      acc[k] = 1'b0;
      if (m_left[k] > 0) begin
        e_data[k]  = COMMA_W;
        e_comma[k] = 4'b0001;
        m_run[k]   = 0;
        m_left[k]  = realign ? ALIGN_LEN : m_left[k] - 1;
      end else begin
        if (valid && m_run[k] < per_of(k) - 1) begin
          acc[k]     = 1'b1;
          e_data[k]  = din;
          e_comma[k] = 4'b0000;
          m_run[k]++;
        end else begin
          e_data[k]  = COMMA_W;
          e_comma[k] = 4'b0001;
          m_run[k]   = 0;
        end
        if (realign) m_left[k] = ALIGN_LEN;
      end
      e_rdy[k] = (m_left[k] == 0) && (m_run[k] < per_of(k) - 1);
      e_al[k]  = (m_left[k] == 0);
    end
  endtask

  task automatic step(string tag);
    if (rstn) predict();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(string tag);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_all({tag, "_async"});
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    rstn = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic        ra;
    logic [31:0] d;
    logic [31:0] ed;
    logic [3:0]  ec;
    logic        er;
    logic        ea;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int  run_len;
    bit  seen;

    // Expected behaviour of the PERIOD=4 instance, starting in RUN right after an idle comma.
    tbl[0]  = '{1'b1, 1'b0, 32'hA1, 32'hA1,  4'h0, 1'b1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 32'hA2, 32'hA2,  4'h0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 32'hA3, 32'hA3,  4'h0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 32'hA4, COMMA_W, 4'h1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 32'hA4, 32'hA4,  4'h0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 32'hA5, COMMA_W, 4'h1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 32'hA5, 32'hA5,  4'h0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'hA6, COMMA_W, 4'h1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'hA6, 32'hA6,  4'h0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 32'hA7, 32'hA7,  4'h0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 32'hA8, COMMA_W, 4'h1, 1'b0, 1'b0};

    model_reset();
    #1;
    rstn = 1'b0;
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_held");
    rstn = 1'b1;

    // Alignment burst after release, then a couple of idle commas.
    for (int i = 0; i < ALIGN_LEN; i++) step("burst");
    chk("burst", "aligned_after", 32'(al1), 32'd1);
    repeat (2) step("idle");

    for (int i = 0; i < 11; i++) begin
      valid   = tbl[i].v;
      realign = tbl[i].ra;
      din     = tbl[i].d;
      step("vec_model");
      chk("vec", "data",    dout1, tbl[i].ed);
      chk("vec", "comma",   32'(cm1), 32'(tbl[i].ec));
      chk("vec", "ready",   32'(rdy1), 32'(tbl[i].er));
      chk("vec", "aligned", 32'(al1), 32'(tbl[i].ea));
      $display("vec %0d: valid=%0b realign=%0b din=%h -> data=%h comma=%b ready=%0b aligned=%0b",
               i, tbl[i].v, tbl[i].ra, tbl[i].d, dout1, cm1, rdy1, al1);
      realign = 1'b0;
    end
    valid = 1'b0;
    repeat (ALIGN_LEN - 1) step("realign_burst");
    chk("realign", "aligned_after", 32'(al0), 32'd1);

    // Continuous stream on the PERIOD=1024 instance: 1023 data words, then one forced comma.
    valid   = 1'b1;
    din     = 32'd1;
    run_len = 0;
    seen    = 1'b0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      step("stream");
      if (acc[0]) din++;
      if (cm0 == 4'b0000) run_len++;
      else seen = 1'b1;
    end
    chk("stream", "forced_comma_seen", 32'(seen), 32'd1);
    chk("stream", "data_run", 32'(run_len), 32'd1023);
    step("stream_resume");
    chk("stream", "resume_word", dout0, 32'd1024);
    repeat (4) begin
      step("stream_tail");
      if (acc[0]) din++;
    end

    // Reset in RUN, then again part-way through the burst.
    do_reset("rst_run");
    repeat (5) step("partial_burst");
    do_reset("rst_align");
    for (int i = 0; i < ALIGN_LEN; i++) step("burst2");
    chk("burst2", "aligned_after", 32'(al0), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      valid   = ($urandom_range(0, 3) != 0);
      realign = ($urandom_range(0, 149) == 0);
      din     = $urandom;
      if ($urandom_range(0, 999) == 0) do_reset("rand_rst");
      else step("rand");
    end
    realign = 1'b0;
    valid   = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
